updown_counter: RTL

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/counter_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 31 +++
 rtl/updown_counter.sv | 86 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter and its prescaler.
package counter_pkg;

  localparam int COUNT_WRAP = 0;
  localparam int COUNT_SAT  = 1;

  // Bits needed to hold prescaler phases 0..prescale-1 (at least one bit).
  function automatic int prescale_width(input int prescale);
    int w;
    w = 1;
    while ((1 << w) < prescale) w++;
    return w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles down to one tick every PRESCALE-th enabled cycle.
// Phase holds while en=0 and clears on rst or clr.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int             PW   = prescale_width(PRESCALE);
  localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = en && (phase == LAST);

  // Phase counter: advances only on enabled cycles, restarts after the tick.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Modulo-MODULUS up/down counter with parallel load, terminal count and
// wrap/limit pulse. SATURATE selects wrap-around or hold at the range ends.
// Optional prescaler enabled by macro UPDOWN_COUNTER_PRESCALE_EN.
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
`ifdef UPDOWN_COUNTER_PRESCALE_EN
  ,
  parameter int PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam bit               SAT  = (SATURATE == COUNT_SAT);

  logic             step;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (en),
    .tick (step)
  );
`else
  assign step = en;
`endif

  assign tc = up ? (count == MAX) : (count == ZERO);

  // Next-count selection: load beats step, step beats hold; limits wrap or hold.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = (din > MAX) ? MAX : din;
    end else if (step) begin
      if (up) begin
        if (count == MAX) begin
          wrap_next  = 1'b1;
          count_next = SAT ? MAX : ZERO;
        end else begin
          count_next = count + WIDTH'(1);
        end
      end else begin
        if (count == ZERO) begin
          wrap_next  = 1'b1;
          count_next = SAT ? ZERO : MAX;
        end else begin
          count_next = count - WIDTH'(1);
        end
      end
    end
  end

  // Count and wrap registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

endmodule
